// File: rtl/debounce_bank_if.sv
// Button bank signal bundle: raw inputs toward the debouncer, debounced levels and pulses back.
// The master side drives raw buttons and consumes events; the slave side is the debouncer.
interface debounce_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic         any_press;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat,
        input  any_press
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat,
        output any_press
    );
endinterface

// File: rtl/debounce_bank.sv
// Bank of N independent button debouncers with press/release edge pulses and optional auto-repeat.
// Each channel: 2-flop synchroniser, stability counter gating level changes, repeat down-counter.
module debounce_bank #(
    parameter int N          = 4,
    parameter int STABLE_CYC = 16,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 8
) (
    input logic            clk,
    input logic            rst,
    debounce_bank_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    if (N < 1 || N > 32) begin : g_bad_n
        $error("debounce_bank: N must be in 1..32");
    end
    if (STABLE_CYC < 1 || STABLE_CYC > 65535) begin : g_bad_stable
        $error("debounce_bank: STABLE_CYC must be in 1..65535");
    end
    if (REPEAT_DLY > 0 && REPEAT_PER < 1) begin : g_bad_per
        $error("debounce_bank: REPEAT_PER must be >= 1 when auto-repeat is enabled");
    end

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic          any_press_q, any_press_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    always_comb begin
        sync1_d = bus.btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            // Any agreeing sample drops the count back to zero; only an unbroken run flips the level.
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        press_d     = level_d & ~level_q;
        release_d   = ~level_d & level_q;
        any_press_d = |press_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    if (REPEAT_DLY > 0) begin : g_repeat
        localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
        localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

        logic [RW-1:0] rcnt_q [N];
        logic [RW-1:0] rcnt_d [N];
        logic [N-1:0]  repeat_q, repeat_d;

        // Down-counter preloaded while released, so terminal count lands REPEAT_DLY cycles after press.
        always_comb begin
            for (int i = 0; i < N; i++) begin
                rcnt_d[i]   = rcnt_q[i];
                repeat_d[i] = 1'b0;
                if (!level_q[i]) begin
                    rcnt_d[i] = RW'(REPEAT_DLY - 1);
                end else if (rcnt_q[i] == '0) begin
                    rcnt_d[i]   = RW'(REPEAT_PER - 1);
                    repeat_d[i] = level_d[i];
                end else begin
                    rcnt_d[i] = rcnt_q[i] - RW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                repeat_q <= '0;
                for (int i = 0; i < N; i++) begin
                    rcnt_q[i] <= '0;
                end
            end else begin
                repeat_q <= repeat_d;
                for (int i = 0; i < N; i++) begin
                    rcnt_q[i] <= rcnt_d[i];
                end
            end
        end

        assign bus.btn_repeat = repeat_q;
    end else begin : g_no_repeat
        assign bus.btn_repeat = '0;
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_press   = any_press_q;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N, default 4: number of independent button channels; range 1..32.
REQ-002 Parameter STABLE_CYC, default 16: consecutive synchronised cycles of disagreement required before a level changes; range 1..65535.
REQ-003 Parameter REPEAT_DLY, default 0: cycles a debounced level must stay high before the first repeat pulse; 0 disables auto-repeat.
REQ-004 Parameter REPEAT_PER, default 8: cycles between subsequent repeat pulses; must be >=1 when REPEAT_DLY>0.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 btn_in  input  N  raw asynchronous button inputs, active-high.
REQ-008 btn_level  output  N  debounced level per channel, registered.
REQ-009 btn_press  output  N  one-cycle pulse per channel on debounced 0->1.
REQ-010 btn_release  output  N  one-cycle pulse per channel on debounced 1->0.
REQ-011 btn_repeat  output  N  one-cycle auto-repeat pulse per channel while held.
REQ-012 any_press  output  1  registered OR of btn_press across channels, same cycle as btn_press.

Function
REQ-013 Each channel SHALL pass btn_in[i] through a 2-flop synchroniser; sync value s[i] is the second flop.
REQ-014 Each channel SHALL own a stability counter, width clog2(STABLE_CYC+1), saturating never needed.
REQ-015 If s[i]==btn_level[i], counter SHALL clear to 0 that cycle.
REQ-016 If s[i]!=btn_level[i] and counter<STABLE_CYC-1, counter SHALL increment.
REQ-017 If s[i]!=btn_level[i] and counter==STABLE_CYC-1, btn_level[i] SHALL toggle on the next edge and counter SHALL clear.
REQ-018 Latency: a clean btn_in step SHALL appear on btn_level exactly STABLE_CYC+2 cycles after the first sampling edge.
REQ-019 A glitch shorter than STABLE_CYC synchronised cycles SHALL never change btn_level; any agreeing sample restarts the count from 0.
REQ-020 btn_press[i] SHALL be high exactly in the first cycle btn_level[i] is 1; btn_release[i] exactly in the first cycle btn_level[i] is 0 after being 1.
REQ-021 Per-channel repeat counter SHALL clear whenever btn_level[i] is 0 and count cycles while btn_level[i] is 1.
REQ-022 With REPEAT_DLY>0: first btn_repeat[i] SHALL fire REPEAT_DLY cycles after btn_press[i]; subsequent ones every REPEAT_PER cycles while btn_level[i] stays 1.
REQ-023 btn_repeat[i] SHALL never coincide with btn_press[i] and SHALL stop the cycle btn_level[i] falls (no pulse with btn_release[i]).
REQ-024 With REPEAT_DLY==0, btn_repeat SHALL be constant 0 and repeat counters SHALL be optimised away.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-026 While rst is high: synchronisers, counters, btn_level, btn_press, btn_release, btn_repeat, any_press SHALL all be 0 at the next edge.
REQ-027 Reset asserted mid-count or while held SHALL discard progress; after release a held button SHALL produce btn_press STABLE_CYC+2 cycles after the first non-reset edge, with no btn_release emitted by the reset itself.
REQ-028 No output SHALL pulse in the cycle rst deasserts.

Verification (N=2, STABLE_CYC=4, REPEAT_DLY=6, REPEAT_PER=3)
REQ-029 btn_in[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1, any_press=1 on edge 6 after the step; btn_press low next cycle.
REQ-030 btn_in[0] high 3 cycles then low -> btn_level, btn_press stay 0 throughout.
REQ-031 Bouncing input 1,0,1,1,1,1 -> btn_level rises 6 cycles after the final 0->1, once only.
REQ-032 Hold 20 cycles after press -> btn_repeat[0] at press+6, +9, +12, +15, +18; release -> btn_release[0] once, no further repeat.
REQ-033 Both channels step together -> btn_press=2'b11 in the same cycle, any_press=1 for one cycle.
REQ-034 rst pulsed while btn_level[1]=1 and button held -> outputs 0 during reset, no btn_release, btn_press[1] 6 cycles after rst falls.
